// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: one memory bus port shared by the IFU (read) and LSU (rd/wr).
// Ports: clk, rst_n (async, low); ifu_* / lsu_* requesters; mem_* bus bridge side.
module ysyx_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned LSU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_err,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  output logic [7:0]        mem_rstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_awvalid,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              mem_wvalid,
  input  logic              mem_wready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned SW = $clog2(LSU_BURST + 2);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [SW-1:0] SB_MAX = SW'(LSU_BURST);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;

  logic wr_req;
  logic starve;
  logic g_ifu;
  logic g_wr;
  logic g_rd;

  assign wr_req = lsu_awvalid & lsu_wvalid;
  assign starve = ifu_arvalid & (scnt == SB_MAX);

  // One-hot grant: the starvation guard overrides the
  // fixed order write > read > ifetch.
  assign g_ifu = ifu_arvalid
               & (starve | ~(wr_req | lsu_arvalid));
  assign g_wr  = wr_req & ~g_ifu;
  assign g_rd  = lsu_arvalid & ~wr_req & ~g_ifu;

  logic is_ifu;
  logic is_lrd;
  logic is_lwr;
  logic busy;

  assign is_ifu = (state == IFU_RD);
  assign is_lrd = (state == LSU_RD);
  assign is_lwr = (state == LSU_WR);
  assign busy   = (state != IDLE);

  logic rd_hit;
  logic wr_hit;
  logic resp;
  logic expire;
  logic done;

  assign rd_hit = (is_ifu | is_lrd) & mem_rvalid;
  assign wr_hit = is_lwr & mem_wready;
  assign resp   = rd_hit | wr_hit;
  // tcnt holds the 1-based busy-cycle index, so the
  // forced error lands on busy cycle TIMEOUT; a real
  // response in that same cycle takes precedence.
  assign expire = TO_EN & busy
                & (tcnt == TO_MAX) & ~resp;
  assign done   = resp | expire;

  assign ifu_rvalid = is_ifu & done;
  assign ifu_err    = is_ifu & expire;
  assign ifu_rdata  = (is_ifu & mem_rvalid)
                    ? mem_rdata : '0;

  assign lsu_rvalid = is_lrd & done;
  assign lsu_wready = is_lwr & done;
  assign lsu_err    = (is_lrd | is_lwr) & expire;
  assign lsu_rdata  = (is_lrd & mem_rvalid)
                    ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      scnt        <= '0;
      mem_araddr  <= '0;
      mem_arvalid <= 1'b0;
      mem_rstrb   <= '0;
      mem_awaddr  <= '0;
      mem_awvalid <= 1'b0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      mem_wvalid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= TW'(1);
          if (!ifu_arvalid || g_ifu) begin
            scnt <= '0;
          end else if ((g_wr || g_rd) &&
                       scnt != SB_MAX) begin
            scnt <= scnt + SW'(1);
          end
          unique case (1'b1)
            g_ifu: begin
              state       <= IFU_RD;
              mem_araddr  <= ifu_araddr;
              mem_rstrb   <= 8'hf;
              mem_arvalid <= 1'b1;
            end
            g_wr: begin
              state       <= LSU_WR;
              mem_awaddr  <= lsu_awaddr;
              mem_wdata   <= lsu_wdata;
              mem_wstrb   <= lsu_wstrb;
              mem_awvalid <= 1'b1;
              mem_wvalid  <= 1'b1;
            end
            g_rd: begin
              state       <= LSU_RD;
              mem_araddr  <= lsu_araddr;
              mem_rstrb   <= lsu_rstrb;
              mem_arvalid <= 1'b1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        default: begin
          if (done) begin
            state       <= IDLE;
            mem_arvalid <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_wvalid  <= 1'b0;
          end else if (tcnt != TO_MAX) begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb_ysyx_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model of the arbiter.
module tb_ysyx_mem_arbiter;

  localparam int TO = 8;
  localparam int LB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_err;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_wready;
  logic        lsu_err;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic [7:0]  mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] mem_awaddr;
  logic        mem_awvalid;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_wvalid;
  logic        mem_wready;

  always #5 clk = ~clk;

  ysyx_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .TIMEOUT(TO), .LSU_BURST(LB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .ifu_err(ifu_err),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
    .lsu_rstrb(lsu_rstrb), .lsu_rdata(lsu_rdata),
    .lsu_rvalid(lsu_rvalid), .lsu_awaddr(lsu_awaddr),
    .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_err(lsu_err),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_awaddr(mem_awaddr),
    .mem_awvalid(mem_awvalid), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ifu_araddr  = '0; ifu_arvalid = 1'b0;
    lsu_araddr  = '0; lsu_arvalid = 1'b0;
    lsu_rstrb   = '0; lsu_awaddr  = '0;
    lsu_awvalid = 1'b0; lsu_wdata = '0;
    lsu_wstrb   = '0; lsu_wvalid  = 1'b0;
    mem_rdata   = '0; mem_rvalid  = 1'b0;
    mem_wready  = 1'b0;
  endtask

  // reference model: owner 0 none, 1 ifu, 2 lsu rd, 3 lsu wr
  int          own;
  int          age;
  int          lat;
  int          starve;
  int          n_guard;
  logic [31:0] x_addr;
  logic [31:0] x_data;
  logic [7:0]  x_strb;
  bit          ifu_got;
  bit          lsu_got;

  bit q3[$];
  bit exp3 [6];
  bit ifu_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    #12;
    chk("rst_valids",
        {mem_arvalid, mem_awvalid, mem_wvalid,
         ifu_rvalid, ifu_err, lsu_rvalid,
         lsu_wready, lsu_err}, 0);
    chk("rst_addr", {mem_araddr, mem_awaddr}, 0);
    chk("rst_data", {mem_wdata, mem_wstrb, mem_rstrb}, 0);
    tick();
    rst_n = 1'b1;

    // 1: IFU-only read, response 3 cycles after arvalid
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    tick(); #1;
    chk("t1_arvalid", mem_arvalid, 1);
    chk("t1_araddr", mem_araddr, 32'h8000_0000);
    chk("t1_rstrb", mem_rstrb, 8'hf);
    chk("t1_early", ifu_rvalid, 0);
    tick(); tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    #1;
    chk("t1_rvalid", {ifu_rvalid, ifu_err}, 2'b10);
    chk("t1_rdata", ifu_rdata, 32'h413);
    chk("t1_lsu_quiet", {lsu_rvalid, lsu_rdata}, 0);
    tick();
    clr();
    #1;
    chk("t1_drop", {mem_arvalid, ifu_rvalid}, 0);

    // 2: IFU read and LSU write together
    ifu_araddr  = 32'h8000_0000; ifu_arvalid = 1'b1;
    lsu_awaddr  = 32'h8000_0100; lsu_wdata = 32'hdead_beef;
    lsu_wstrb   = 8'h1;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    tick(); #1;
    chk("t2_wr_first",
        {mem_awvalid, mem_wvalid, mem_arvalid}, 3'b110);
    chk("t2_awaddr", mem_awaddr, 32'h8000_0100);
    chk("t2_wdata", mem_wdata, 32'hdead_beef);
    chk("t2_wstrb", mem_wstrb, 8'h1);
    tick();
    mem_wready = 1'b1; mem_rdata = 32'h5555_aaaa;
    #1;
    chk("t2_wready", {lsu_wready, lsu_err, ifu_rvalid}, 3'b100);
    chk("t2_ifu_rdata", ifu_rdata, 0);
    tick();
    mem_wready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    #1;
    chk("t2_bubble", {mem_awvalid, mem_arvalid}, 0);
    tick(); #1;
    chk("t2_ifu_grant", mem_arvalid, 1);
    chk("t2_ifu_addr", mem_araddr, 32'h8000_0000);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("t2_ifu_data", {ifu_rvalid, ifu_rdata}, {1'b1, 32'h1234_5678});
    tick();
    clr();

    // 3: starvation guard
    exp3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ifu_araddr = 32'h1000; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h2000; lsu_arvalid = 1'b1;
    lsu_rstrb  = 8'h3;
    ifu_done = 1'b0;
    for (int c = 0; c < 40 && q3.size() < 6; c++) begin
      tick();
      if (ifu_done) ifu_arvalid = 1'b0;
      mem_rvalid = mem_arvalid;
      mem_rdata  = $urandom;
      #1;
      if (mem_arvalid) q3.push_back(mem_araddr == 32'h1000);
      ifu_done = ifu_rvalid;
    end
    chk("t3_count", q3.size(), 6);
    for (int i = 0; i < 6 && i < q3.size(); i++)
      chk($sformatf("t3_grant%0d", i), q3[i], exp3[i]);
    tick();
    clr();
    tick();

    // 4: timeout on an LSU read
    lsu_araddr = 32'h40; lsu_arvalid = 1'b1;
    lsu_rstrb = 8'hff;
    tick();
    for (int k = 1; k <= TO; k++) begin
      mem_rdata = 32'hcafe_0000 + k;
      #1;
      chk($sformatf("t4_age%0d", k),
          {lsu_rvalid, lsu_err}, (k == TO) ? 2'b11 : 2'b00);
      if (k == TO) chk("t4_rdata", lsu_rdata, 0);
      tick();
    end
    lsu_arvalid = 1'b0;
    #1;
    chk("t4_drop", {mem_arvalid, lsu_rvalid}, 0);
    tick();

    // 5: LSU address change after grant is ignored
    lsu_araddr = 32'h10; lsu_arvalid = 1'b1;
    tick(); #1;
    chk("t5_grant", mem_araddr, 32'h10);
    lsu_araddr = 32'h20;
    tick(); #1;
    chk("t5_hold", mem_araddr, 32'h10);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("t5_resp", {lsu_rvalid, lsu_rdata, mem_araddr},
        {1'b1, 32'h77, 32'h10});
    tick();
    clr();
    tick();

    // 6: reset asserted mid write
    lsu_awaddr = 32'h300; lsu_wdata = 32'h99;
    lsu_wstrb = 8'hf; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    tick(); tick();
    chk("t6_busy", mem_wvalid, 1);
    rst_n = 1'b0;
    clr();
    #1;
    chk("t6_rst", {mem_wvalid, mem_awvalid, mem_awaddr}, 0);
    tick();
    rst_n = 1'b1;
    mem_wready = 1'b1;
    #1;
    chk("t6_stray", lsu_wready, 0);
    tick();
    mem_wready = 1'b0;
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    tick(); #1;
    chk("t6_next", {mem_arvalid, mem_araddr}, {1'b1, 32'h8000_0004});
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h13;
    #1;
    chk("t6_resp", {ifu_rvalid, ifu_rdata}, {1'b1, 32'h13});
    tick();
    clr();

    // randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    own = 0; age = 0; lat = 0; starve = 0; n_guard = 0;
    x_addr = '0; x_data = '0; x_strb = '0;
    ifu_got = 1'b0; lsu_got = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit w;
      bit r;
      bit i;
      bit rsp;
      bit exr;
      bit e_ifu;
      bit e_lrd;
      bit e_lwr;
      int kind;
      @(posedge clk);
      #1;
      if (ifu_got || !ifu_arvalid)
        ifu_arvalid = ($urandom_range(0, 99) < 60);
      ifu_araddr = $urandom;
      if (lsu_got || !(lsu_arvalid || lsu_wvalid)) begin
        kind = $urandom_range(0, 4);
        lsu_arvalid = (kind == 1 || kind == 2);
        lsu_wvalid  = (kind >= 3);
        lsu_awvalid = lsu_wvalid;
      end
      lsu_araddr = $urandom; lsu_rstrb = 8'($urandom);
      lsu_awaddr = $urandom; lsu_wdata = $urandom;
      lsu_wstrb  = 8'($urandom);
      mem_rdata  = $urandom;
      mem_rvalid = 1'b0; mem_wready = 1'b0;
      if (own != 0 && age == lat) begin
        if (own == 3) mem_wready = 1'b1;
        else mem_rvalid = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        if (own == 0) begin
          mem_rvalid = 1'($urandom);
          mem_wready = 1'($urandom);
        end else if (own == 3) mem_rvalid = 1'b1;
        else mem_wready = 1'b1;
      end
      @(negedge clk);
      rsp = (own == 1 || own == 2) && mem_rvalid
         || (own == 3) && mem_wready;
      exr = (own != 0) && (age == TO) && !rsp;
      e_ifu = (own == 1) && (rsp || exr);
      e_lrd = (own == 2) && (rsp || exr);
      e_lwr = (own == 3) && (rsp || exr);
      chk("rnd_pulse",
          {ifu_rvalid, ifu_err, lsu_rvalid, lsu_wready, lsu_err},
          {e_ifu, (own == 1) && exr, e_lrd, e_lwr,
           (own >= 2) && exr});
      chk("rnd_valid", {mem_arvalid, mem_awvalid, mem_wvalid},
          {own == 1 || own == 2, own == 3, own == 3});
      chk("rnd_rdata", {ifu_rdata, lsu_rdata},
          {(own == 1 && rsp) ? mem_rdata : 32'h0,
           (own == 2 && rsp) ? mem_rdata : 32'h0});
      if (own == 1 || own == 2)
        chk("rnd_rd_req", {mem_araddr, mem_rstrb},
            {x_addr, x_strb});
      if (own == 3)
        chk("rnd_wr_req", {mem_awaddr, mem_wdata, mem_wstrb},
            {x_addr, x_data, x_strb});
      ifu_got = e_ifu;
      lsu_got = e_lrd || e_lwr;
      if (own != 0) begin
        if (rsp || exr) own = 0;
        else age++;
      end else begin
        w = lsu_awvalid && lsu_wvalid;
        r = lsu_arvalid;
        i = ifu_arvalid;
        if (i && starve == LB) begin
          own = 1;
          if (w || r) n_guard++;
        end
        else if (w) own = 3;
        else if (r) own = 2;
        else if (i) own = 1;
        if (!i || own == 1) starve = 0;
        else if (own >= 2 && starve < LB) starve++;
        if (own != 0) begin
          age = 1;
          lat = $urandom_range(1, TO + 3);
        end
        if (own == 1) begin
          x_addr = ifu_araddr; x_strb = 8'hf;
        end else if (own == 2) begin
          x_addr = lsu_araddr; x_strb = lsu_rstrb;
        end else if (own == 3) begin
          x_addr = lsu_awaddr; x_data = lsu_wdata;
          x_strb = lsu_wstrb;
        end
      end
    end
    chk("rnd_guard_seen", n_guard > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
